// File: rtl/div32_iter_pkg.sv
// div_pkg: shared definitions for the iterative divider.
//   div_state_t  : divider sequencing states (IDLE, CALC, FIX)
//   DIV_WIDTH    : operand width
//   DIV_LATENCY  : edges from accept to the out_en cycle
//   DIV_CNT_W    : width of the quotient-bit counter
//   condNeg()    : two's-complement negate when the flag is set; used both to
//                  form operand magnitudes and to restore result signs
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH + 1);

  function automatic logic [DIV_WIDTH-1:0] condNeg(input logic [DIV_WIDTH-1:0] value,
                                                   input logic                 neg);
    return neg ? (~value + DIV_WIDTH'(1)) : value;
  endfunction

endpackage

// File: rtl/div32_iter.sv
// div32_iter: iterative radix-2 restoring divider, DIV/DIVU/REM/REMU with
// RISC-V semantics (divide-by-zero and signed overflow included). Fixed
// latency: a request accepted at edge E0 produces an out_en pulse in the
// cycle after edge E0+WIDTH+1.
// Ports:
//   clk        clock
//   rst        synchronous, active-low reset
//   in_en      request strobe, honoured only while idle
//   a, b       dividend / divisor
//   div_signed 1 = two's-complement operands
//   out_en     one-cycle completion pulse
//   idle       a request may be presented this cycle
//   q, rem     quotient / remainder, held until the next completion
module div32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             div_signed,
  output logic             out_en,
  output logic             idle,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem
);

  div_state_t             state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]         prem_q, prem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic [WIDTH-1:0]       aOrig_q, aOrig_d;
  logic                   signA_q, signA_d;
  logic                   signB_q, signB_d;
  logic                   zero_q, zero_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic                   outEn_q, outEn_d;

  logic [WIDTH:0]         trial;
  logic [WIDTH:0]         diff;
  logic                   quoBit;

  // After a restoring step the partial remainder is always below |b|, so its
  // top bit is zero on entry to every step; the shifted value is rebuilt from
  // the low WIDTH bits and the extra bit only protects the compare.
  logic                   unusedPremMsb;
  assign unusedPremMsb = prem_q[WIDTH];

  // Next-state and datapath. quo_q starts as |a| and is shifted left one bit
  // per CALC step while quotient bits enter at the bottom, so after WIDTH
  // steps it holds |q| and prem_q holds |rem|.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    aOrig_d = aOrig_q;
    signA_d = signA_q;
    signB_d = signB_q;
    zero_d  = zero_q;
    q_d     = q_q;
    rem_d   = rem_q;
    outEn_d = 1'b0;
    trial   = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvsr_q};
    quoBit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_en) begin
          signA_d = div_signed & a[WIDTH-1];
          signB_d = div_signed & b[WIDTH-1];
          quo_d   = condNeg(a, signA_d);
          dvsr_d  = condNeg(b, signB_d);
          aOrig_d = a;
          zero_d  = (b == '0);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (trial >= {1'b0, dvsr_q}) begin
          prem_d = diff;
          quoBit = 1'b1;
        end else begin
          prem_d = trial;
        end
        quo_d = {quo_q[WIDTH-2:0], quoBit};
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Min-int / -1 needs no special case: |q| = 2^(WIDTH-1) and equal
        // signs leave it unnegated, which is exactly the overflow result.
        if (zero_q) begin
          q_d   = '1;
          rem_d = aOrig_q;
        end else begin
          q_d   = condNeg(quo_q, signA_q ^ signB_q);
          rem_d = condNeg(prem_q[WIDTH-1:0], signA_q);
        end
        outEn_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight
  // without producing a completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      aOrig_q <= '0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      rem_q   <= '0;
      outEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      aOrig_q <= aOrig_d;
      signA_q <= signA_d;
      signB_q <= signB_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      outEn_q <= outEn_d;
    end
  end

  // idle drops as soon as a request is presented so an issuer never sees
  // idle=1 on the edge its own request is taken.
  assign idle   = (state_q == IDLE) & ~in_en;
  assign out_en = outEn_q;
  assign q      = q_q;
  assign rem    = rem_q;

endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: self-checking bench for div32_iter. Directed cases cover
// the documented corner values; randomized operations are compared against
// a plain-arithmetic RISC-V division model.
module tb_div32_iter;

  localparam int LATENCY = 34;
  // out_en is observed in the cycle following edge E0+LATENCY-1
  localparam int OUT_EDGE = LATENCY - 1;

  logic        clk;
  logic        rst;
  logic        in_en;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_signed;
  logic        out_en;
  logic        idle;
  logic [31:0] q;
  logic [31:0] rem;

  int checkCount = 0;
  int passCount  = 0;

  div32_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .a          (a),
    .b          (b),
    .div_signed (div_signed),
    .out_en     (out_en),
    .idle       (idle),
    .q          (q),
    .rem        (rem)
  );

  // Free-running clock; inputs change and outputs are sampled on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V division rules in ordinary arithmetic.
  function automatic void refDiv(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                 output logic [31:0] eq, output logic [31:0] er);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = av;
    sb = bv;
    if (bv == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = av;
    end else if (sv) begin
      if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        eq = 32'h8000_0000;
        er = 32'd0;
      end else begin
        eq = sa / sb;
        er = sa % sb;
      end
    end else begin
      eq = av / bv;
      er = av % bv;
    end
  endfunction

  // Issue one request from a negedge, optionally inject a stray in_en pulse
  // while busy, and check latency, busy-idle and the result. Returns at the
  // negedge of the out_en cycle.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                               input logic [31:0] eq, input logic [31:0] er,
                               input string tag, input int pulseAt);
    int edges;
    int busyIdle;
    checkOutput({tag, "_idle_pre"}, 64'(idle), 64'd1);
    a          = av;
    b          = bv;
    div_signed = sv;
    in_en      = 1'b1;
    @(posedge clk);
    edges    = 0;
    busyIdle = 0;
    @(negedge clk);
    in_en = 1'b0;
    while (out_en !== 1'b1 && edges < 100) begin
      if (idle !== 1'b0) busyIdle++;
      if (edges == pulseAt) begin
        in_en      = 1'b1;
        a          = $urandom;
        b          = $urandom;
        div_signed = 1'b1;
      end else begin
        in_en = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    in_en = 1'b0;
    checkOutput({tag, "_latency"}, 64'(edges), 64'(OUT_EDGE));
    checkOutput({tag, "_busy_idle"}, 64'(busyIdle), 64'd0);
    checkOutput({tag, "_q"}, 64'(q), 64'(eq));
    checkOutput({tag, "_rem"}, 64'(rem), 64'(er));
  endtask

  task automatic checkPulseEnd(input string tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 64'(out_en), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] eq;
    logic [31:0] er;
    int          seen;

    rst        = 1'b0;
    in_en      = 1'b0;
    a          = '0;
    b          = '0;
    div_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    checkOutput("reset_q", 64'(q), 64'd0);
    checkOutput("reset_rem", 64'(rem), 64'd0);
    checkOutput("reset_out_en", 64'(out_en), 64'd0);
    checkOutput("reset_idle", 64'(idle), 64'd1);

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "udiv", -1);
    checkPulseEnd("udiv");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "sdiv_neg_a", -1);
    checkPulseEnd("sdiv_neg_a");
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "sdiv_neg_b", -1);
    checkPulseEnd("sdiv_neg_b");
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div0_s", -1);
    checkPulseEnd("div0_s");
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div0_u", -1);
    checkPulseEnd("div0_u");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "ovf_s", -1);
    checkPulseEnd("ovf_s");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "ovf_u", -1);
    checkPulseEnd("ovf_u");

    // Second request presented in the first one's out_en cycle.
    applyStimulus(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, "b2b_first", -1);
    applyStimulus(32'hFFFF_FC18, 32'd33, 1'b1, 32'hFFFF_FFE2, 32'hFFFF_FFF6, "b2b_second", -1);
    checkPulseEnd("b2b_second");

    // Stray in_en while busy must not disturb the running operation.
    applyStimulus(32'd123456, 32'd789, 1'b0, 32'd156, 32'd372, "stray_calc", 5);
    checkPulseEnd("stray_calc");
    applyStimulus(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "stray_fix", OUT_EDGE - 1);
    checkPulseEnd("stray_fix");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: rb = {1'b1, rb[30:0]};
        default: ;
      endcase
      refDiv(ra, rb, rs, eq, er);
      applyStimulus(ra, rb, rs, eq, er, $sformatf("rand%0d", i), -1);
      checkPulseEnd($sformatf("rand%0d", i));
    end

    // Leave a nonzero result in q/rem, then reset in the middle of CALC.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "pre_reset", -1);
    checkPulseEnd("pre_reset");
    a          = 32'd999;
    b          = 32'd4;
    div_signed = 1'b0;
    in_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_en = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midreset_q", 64'(q), 64'd0);
    checkOutput("midreset_rem", 64'(rem), 64'd0);
    checkOutput("midreset_out_en", 64'(out_en), 64'd0);
    checkOutput("midreset_idle", 64'(idle), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_en === 1'b1) seen++;
    end
    checkOutput("midreset_no_pulse", 64'(seen), 64'd0);
    applyStimulus(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, "post_reset", -1);
    checkPulseEnd("post_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/div32_iter.md
# div32_iter

Iterative radix-2 restoring divider for the execution back end. It serves the divide reservation station: one operation is accepted through a single-cycle `in_en` pulse, and one result is returned through a single-cycle `out_en` pulse. The block computes quotient and remainder for DIV/DIVU/REM/REMU with RISC-V semantics, including divide-by-zero and signed overflow. It processes one operation at a time and advertises availability on `idle`.

## Interface
- `WIDTH`, default 32: operand width. Fixed latency is WIDTH+2 edges.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `in_en` in 1: accept request; honoured only while internally idle.
- `a` in WIDTH: dividend.
- `b` in WIDTH: divisor.
- `div_signed` in 1: 1 = two's-complement operands, 0 = unsigned.
- `out_en` out 1: one-cycle pulse; `q`/`rem` valid in this cycle.
- `idle` out 1: 1 = a request may be presented this cycle.
- `q` out WIDTH: quotient; holds its value until the next completion.
- `rem` out WIDTH: remainder; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, on an edge with `in_en`=1:
  - latch the sign flags `sa = div_signed & a[MSB]` and `sb = div_signed & b[MSB]`;
  - latch magnitudes `|a|` and `|b|` (negate when the sign flag is set);
  - latch `zero = (b == 0)`;
  - clear the partial remainder and the count; go to CALC.
- CALC, one quotient bit per edge, MSB first:
  - shift `{prem, dividend}` left by 1;
  - if `prem >= |b|`, subtract `|b|` and set the quotient bit to 1;
  - after WIDTH bits, go to FIX.
  - `prem` is WIDTH+1 bits wide so the compare cannot overflow.
- FIX, one edge; register `q`/`rem` and set `out_en`=1 for the following cycle, then return to IDLE:
  - if `zero`: `q` = all ones, `rem` = `a` (the original, unnegated dividend).
  - otherwise: `q` = `sa^sb ? -qmag : qmag` and `rem` = `sa ? -rmag : rmag`.
  - Signed overflow (min-int / -1) falls out of these rules as `q` = 0x80000000, `rem` = 0. No special case is required.
- `idle = (state == IDLE) & !in_en`. Because this is combinational from `in_en`, an issuer that registers its request never sees `idle`=1 on the edge its own request is accepted.
- `in_en` while in CALC or FIX is a protocol violation. It is ignored and the operation in flight is unaffected.
- `out_en` and `idle` may both be 1 in the same cycle. A request presented in the `out_en` cycle is accepted at the next edge.
- Reset (`rst`=0 at an edge), from any state including mid-CALC:
  - state goes to IDLE; the in-flight result is discarded with no `out_en` pulse;
  - `out_en`=0, `q`=0, `rem`=0, count=0;
  - `idle`=1 in the following cycle, provided `in_en`=0.

## Timing
- Accept edge E0. Quotient-bit edges E1..E32. FIX edge E33.
- `out_en`=1 during exactly the cycle after E33, i.e. WIDTH+2 edges after E0. It is 0 in every other cycle.
- `q`/`rem` change only at the FIX edge or at reset.
- Latency is identical for every input, including divide-by-zero and overflow.
- Maximum throughput: one operation per WIDTH+2 cycles.
- No combinational path from `a`/`b` to any output. The only such path is `in_en` → `idle`.

## Structure
- Shared package `div_pkg`:
  - state enum `div_state_t` {IDLE, CALC, FIX};
  - `DIV_WIDTH` = 32;
  - `DIV_LATENCY` = DIV_WIDTH+2;
  - count width `$clog2(DIV_WIDTH+1)`.
- Single module, no sub-modules. Conditional negation is a package function used for both input magnitude and output fix.

## Test plan
- Unsigned: `a`=100, `b`=7, `div_signed`=0 → `q`=14, `rem`=2. `out_en` is high only in the cycle after E0+33; `idle`=0 from E0 through E33.
- Signed: `a`=0xFFFFFFF9 (-7), `b`=2, `div_signed`=1 → `q`=0xFFFFFFFD, `rem`=0xFFFFFFFF. Also 7 / -2 → `q`=0xFFFFFFFD, `rem`=1.
- Divide-by-zero: `a`=0xFFFFFFFB, `b`=0, `div_signed`=1 → `q`=0xFFFFFFFF, `rem`=0xFFFFFFFB. The same operands with `div_signed`=0 give an identical result. Latency is still 34 edges.
- Overflow: `a`=0x80000000, `b`=0xFFFFFFFF, `div_signed`=1 → `q`=0x80000000, `rem`=0. With `div_signed`=0 → `q`=0, `rem`=0x80000000.
- Back-to-back: second request held from the `out_en` cycle of the first → accepted at the next edge, second `out_en` exactly 34 edges later. An `in_en` pulse during CALC is ignored, and the first result is unchanged.
- Reset: `rst`=0 for one edge at E0+10 → no `out_en` pulse; `q`=`rem`=0; `idle`=1 in the next cycle. A following 0xFFFFFFFF/0x10 unsigned request → `q`=0x0FFFFFFF, `rem`=0xF.
